// File: rtl/ram_fifo_pkg.sv
// rtl/ram_fifo_pkg.sv - shared constants and types for the RAM-backed sample FIFO
package ram_fifo_pkg;

  localparam int FIFO_DEPTH   = 1024;
  localparam int LEVEL_W      = 11;
  localparam int OSTAGE_DEPTH = 2;

  typedef logic [8:0] sample_t;

endpackage

// File: rtl/ram_1024x9.sv
// rtl/ram_1024x9.sv - simple dual-port RAM, 1-cycle read latency plus optional output register
module ram_1024x9 #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 9,
  parameter bit OUTPUT_REG  = 1'b0,
  parameter bit ASYNC_RESET = 1'b1
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] pipe_q;

  // Array contents are never reset; only the read registers are.
  always_ff @(posedge wr_clk) begin
    if (wr_en && !wr_rst) mem[wr_addr] <= wr_data;
  end

  if (ASYNC_RESET) begin : g_arst
    always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
        rd_q   <= '0;
        pipe_q <= '0;
      end else begin
        if (rd_en) rd_q <= mem[rd_addr];
        pipe_q <= rd_q;
      end
    end
  end else begin : g_srst
    always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
        rd_q   <= '0;
        pipe_q <= '0;
      end else begin
        if (rd_en) rd_q <= mem[rd_addr];
        pipe_q <= rd_q;
      end
    end
  end

  assign rd_data = OUTPUT_REG ? pipe_q : rd_q;

endmodule

// File: rtl/ram_1024x9_fifo_ctrl.sv
// rtl/ram_1024x9_fifo_ctrl.sv - first-word-fall-through FIFO over one ram_1024x9
module ram_1024x9_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 9,
  parameter int AFULL_THRESH = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]      level_q, level_d;
  logic                  afull_q, afull_d;

  logic                  push, pop, rd_go;
  logic [2:0]            ostage_need;
  logic [DATA_WIDTH-1:0] rd_data;

  assign s_ready = (ram_cnt_q != DEPTH) && !flush;
  assign m_valid = (out_cnt_q != 2'd0);
  assign m_data  = head_q;
  assign level   = level_q;
  assign almost_full = afull_q;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready && !flush;

  // Slots the output stage will still occupy after this cycle's pop, counting the read in flight.
  assign ostage_need = {1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_go = (ram_cnt_q != '0) && (ostage_need < 3'(OSTAGE_DEPTH)) && !flush;

  ram_1024x9 #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .OUTPUT_REG (1'b0),
    .ASYNC_RESET(1'b1)
  ) u_ram (
    .wr_clk (clk),
    .wr_rst (~rst_n),
    .wr_en  (push),
    .wr_addr(wr_ptr_q),
    .wr_data(s_data),
    .rd_clk (clk),
    .rd_rst (~rst_n),
    .rd_en  (rd_go),
    .rd_addr(rd_ptr_q),
    .rd_data(rd_data)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(rd_go);
    ram_cnt_d  = ram_cnt_q + CNT_W'(push) - CNT_W'(rd_go);
    inflight_d = rd_go;
    head_d     = head_q;
    tail_d     = tail_q;
    out_cnt_d  = out_cnt_q;

    if (pop) begin
      head_d    = tail_q;
      out_cnt_d = out_cnt_d - 2'd1;
    end
    // Returning read lands in the first slot left free after the pop.
    if (inflight_q) begin
      if (out_cnt_d == 2'd0) head_d = rd_data;
      else                   tail_d = rd_data;
      out_cnt_d = out_cnt_d + 2'd1;
    end

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      inflight_d = 1'b0;
      out_cnt_d  = 2'd0;
      head_d     = '0;
      tail_d     = '0;
    end

    level_d = ram_cnt_d + CNT_W'(inflight_d) + CNT_W'(out_cnt_d);
    afull_d = (level_d >= CNT_W'(AFULL_THRESH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      out_cnt_q  <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= '0;
      afull_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      out_cnt_q  <= out_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      afull_q    <= afull_d;
    end
  end

endmodule
